// File: rtl/cardio_pkg.sv
// Shared types, widths and LFSR helpers for the cardio share packer.
package cardio_pkg;

    localparam int REC_W = 56;
    localparam int X_W   = 112;

    // Feedback taps of the 56-bit Fibonacci mask generator.
    localparam int LFSR_TAP0 = 55;
    localparam int LFSR_TAP1 = 54;
    localparam int LFSR_TAP2 = 34;
    localparam int LFSR_TAP3 = 33;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        OUT     = 2'd2
    } pack_state_t;

    function automatic logic [REC_W-1:0] lfsr_next(input logic [REC_W-1:0] s);
        logic fb;
        fb = s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3];
        return {s[REC_W-2:0], fb};
    endfunction

    // An all-zero LFSR would lock up, so zero seeds are forced to 1.
    function automatic logic [REC_W-1:0] seed_guard(input logic [REC_W-1:0] s);
        return (s == '0) ? {{(REC_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/cardio_mask_lfsr.sv
// 56-bit mask generator: steps once per delivered record, optional reload.
module cardio_mask_lfsr
    import cardio_pkg::*;
#(
    parameter logic [REC_W-1:0] SEED = 56'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [REC_W-1:0] load_val,
    output logic [REC_W-1:0] mask
);

    localparam logic [REC_W-1:0] RST_VAL = (SEED == '0) ? 56'h1 : SEED;

    // Load wins over step; the two never coincide since they belong to different states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= RST_VAL;
        end else if (load) begin
            mask <= seed_guard(load_val);
        end else if (step) begin
            mask <= lfsr_next(mask);
        end
    end

endmodule

// File: rtl/cardio_share_packer.sv
// Byte-stream record packer producing two XOR shares {mask, record ^ mask}.
// Optional build macro CARDIO_PACK_SEED_LOAD_EN adds seed_load/seed_val ports.
//
// state   | meaning
// --------+-------------------------------------------------------
// COLLECT | accepting record bytes 0..6
// DRAIN   | discarding the tail of an over-long record until in_last
// OUT     | share vector held on out_x until out_ready
module cardio_share_packer
    import cardio_pkg::*;
#(
    parameter int               REC_BYTES = 7,
    parameter logic [REC_W-1:0] SEED      = 56'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   out_x,
    output logic             err_pulse
`ifdef CARDIO_PACK_SEED_LOAD_EN
    ,
    input  logic             seed_load,
    input  logic [REC_W-1:0] seed_val
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

    pack_state_t        state_q, state_d;
    logic [2:0]         byte_idx, idx_d;
    logic [REC_W-9:0]   rec_q;
    logic [REC_W-1:0]   rec_full;
    logic [REC_W-1:0]   mask;
    logic               xfer, wr_byte, cap, err_d, lfsr_step;
    logic               lfsr_load;
    logic [REC_W-1:0]   lfsr_load_val;

    assign xfer      = in_valid && in_ready;
    assign in_ready  = (state_q != OUT);
    assign out_valid = (state_q == OUT);
    assign rec_full  = {in_data, rec_q};

`ifdef CARDIO_PACK_SEED_LOAD_EN
    // Reseeding is only honoured between records.
    assign lfsr_load     = seed_load && (state_q == COLLECT) && (byte_idx == 3'd0);
    assign lfsr_load_val = seed_val;
`else
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = '0;
`endif

    cardio_mask_lfsr #(.SEED(SEED)) u_mask (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .mask     (mask)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_d   = state_q;
        idx_d     = byte_idx;
        err_d     = 1'b0;
        wr_byte   = 1'b0;
        cap       = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (xfer) begin
                    if (byte_idx == LAST_IDX) begin
                        idx_d = 3'd0;
                        if (in_last) begin
                            cap     = 1'b1;
                            state_d = OUT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (in_last) begin
                        err_d = 1'b1;
                        idx_d = 3'd0;
                    end else begin
                        wr_byte = 1'b1;
                        idx_d   = byte_idx + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (xfer && in_last) begin
                    state_d = COLLECT;
                    idx_d   = 3'd0;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d   = COLLECT;
                    lfsr_step = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Byte index, error pulse, partial record and output vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 3'd0;
            err_pulse <= 1'b0;
            rec_q     <= '0;
            out_x     <= '0;
        end else begin
            byte_idx  <= idx_d;
            err_pulse <= err_d;
            for (int b = 0; b < REC_BYTES - 1; b++) begin
                if (wr_byte && (byte_idx == 3'(b))) begin
                    rec_q[b*8 +: 8] <= in_data;
                end
            end
            // The final byte bypasses rec_q so the vector is ready the next cycle.
            if (cap) begin
                out_x <= {mask, rec_full ^ mask};
            end
        end
    end

endmodule

// File: tb/tb_cardio_share_packer.sv
// Self-checking bench for cardio_share_packer: directed table plus random model run.
module tb_cardio_share_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [111:0] out_x;
    logic         err_pulse;
`ifdef CARDIO_PACK_SEED_LOAD_EN
    logic         seed_load = 1'b0;
    logic [55:0]  seed_val = 56'h0;
`endif

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int ov_cnt = 0;

    cardio_share_packer #(.REC_BYTES(7), .SEED(56'h1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .err_pulse (err_pulse)
`ifdef CARDIO_PACK_SEED_LOAD_EN
        ,
        .seed_load (seed_load),
        .seed_val  (seed_val)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        err_cnt += int'(err_pulse);
        ov_cnt  += int'(out_valid);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_rec(input logic [55:0] rec, input int n, input int last_at, output int err_at);
        logic [55:0] r;
        err_at = -1;
        for (int i = 0; i < n; i++) begin
            r        = rec >> (8 * (i % 7));
            in_valid = 1'b1;
            in_data  = r[7:0];
            in_last  = (i == last_at);
            tick();
            if (err_pulse && err_at < 0) err_at = i;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic good_rec(input string tag, input logic [55:0] rec, input logic [55:0] ea,
                            input logic [55:0] eb, input int hold);
        int e;
        send_rec(rec, 7, 6, e);
        chk({tag, " out_valid T+1"}, out_valid, 1);
        chk({tag, " in_ready low"}, in_ready, 0);
        chk({tag, " share_a"}, out_x[55:0], ea);
        chk({tag, " share_b"}, out_x[111:56], eb);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, " hold out_x"}, out_x, {eb, ea});
            chk({tag, " hold in_ready"}, in_ready, 0);
            chk({tag, " hold out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    function automatic logic [55:0] mstep(input logic [55:0] m);
        logic fb;
        fb = m[55] ^ m[54] ^ m[34] ^ m[33];
        return (m << 1) | 56'(fb);
    endfunction

    function automatic int pick_len();
        int r;
        r = int'($urandom % 8);
        if (r < 5) return 7;
        if (r == 5) return 1 + int'($urandom % 6);
        return 8 + int'($urandom % 3);
    endfunction

    typedef struct {
        logic [55:0] rec;
        logic [55:0] exp_a;
        logic [55:0] exp_b;
        int          hold;
    } vec_t;

    vec_t vecs[4];

    // Random-phase reference model state.
    logic [7:0]   bq[$];
    logic [55:0]  mmask, mrec;
    logic [111:0] xexp;
    logic         pend, drain, err_exp, iv, ordy, lst;
    logic [7:0]   d;
    int           gen_len, gen_cnt, good_cnt;

    initial begin
        int e0, e1;

        vecs[0] = '{56'h0123456789ABCD, 56'h0123456789ABCC, 56'h1, 0};
        vecs[1] = '{56'h0123456789ABCD, 56'h0123456789ABCF, 56'h2, 20};
        vecs[2] = '{56'h0, 56'h4, 56'h4, 0};
        vecs[3] = '{56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFF7, 56'h8, 3};

        // Reset values.
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #7;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_x", out_x, 0);
        chk("reset err_pulse", err_pulse, 0);
        do_reset();

        // Short record: in_last on byte 3.
        err_cnt = 0; ov_cnt = 0;
        send_rec(56'h0123456789ABCD, 4, 3, e0);
        chk("short err position", 112'(e0), 3);
        tick();
        chk("short err count", 112'(err_cnt), 1);
        chk("short no out_valid", 112'(ov_cnt), 0);

        // Back-to-back good records, mask advancing 1,2,4,8.
        foreach (vecs[i]) begin
            good_rec($sformatf("table%0d", i), vecs[i].rec, vecs[i].exp_a, vecs[i].exp_b, vecs[i].hold);
        end

        // Long record: ten bytes, in_last on byte 9.
        err_cnt = 0; ov_cnt = 0;
        send_rec(56'h0123456789ABCD, 10, 9, e1);
        chk("long err position", 112'(e1), 6);
        tick();
        chk("long err count", 112'(err_cnt), 1);
        chk("long no out_valid", 112'(ov_cnt), 0);
        good_rec("after long", 56'h0123456789ABCD, 56'h0123456789ABDD, 56'h10, 0);

        // Reset after four bytes of a record.
        send_rec(56'h0123456789ABCD, 4, -1, e0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrec rst in_ready", in_ready, 1);
        chk("midrec rst err_pulse", err_pulse, 0);
        #2 rst_n = 1'b1;
        tick();
        good_rec("after midrec rst", 56'h0123456789ABCD, 56'h0123456789ABCC, 56'h1, 0);

        // Reset while a vector is pending.
        send_rec(56'h00000000000055, 7, 6, e0);
        chk("midout pending", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midout rst out_valid", out_valid, 0);
        chk("midout rst in_ready", in_ready, 1);
        chk("midout rst out_x", out_x, 0);
        #2 rst_n = 1'b1;
        tick();
        good_rec("after midout rst", 56'h0123456789ABCD, 56'h0123456789ABCC, 56'h1, 0);

        // Random traffic against a transaction-level model.
        do_reset();
        pend = 1'b0; drain = 1'b0; err_exp = 1'b0;
        mmask = 56'h1; xexp = '0; bq.delete();
        gen_len = pick_len(); gen_cnt = 0; good_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            chk("rnd in_ready", in_ready, !pend);
            chk("rnd out_valid", out_valid, pend);
            chk("rnd err_pulse", err_pulse, err_exp);
            if (pend) chk("rnd out_x", out_x, xexp);

            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            d    = 8'($urandom);
            lst  = (gen_cnt + 1 == gen_len);
            in_valid  = iv;
            in_data   = d;
            in_last   = lst;
            out_ready = ordy;

            err_exp = 1'b0;
            if (pend) begin
                if (ordy) begin
                    pend  = 1'b0;
                    mmask = mstep(mmask);
                end
            end else if (iv) begin
                gen_cnt++;
                if (gen_cnt == gen_len) begin
                    gen_cnt = 0;
                    gen_len = pick_len();
                end
                if (drain) begin
                    if (lst) drain = 1'b0;
                end else begin
                    bq.push_back(d);
                    if (bq.size() == 7) begin
                        if (lst) begin
                            for (int k = 0; k < 7; k++) mrec[8*k +: 8] = bq[k];
                            xexp = {mmask, mrec ^ mmask};
                            pend = 1'b1;
                            good_cnt++;
                        end else begin
                            err_exp = 1'b1;
                            drain   = 1'b1;
                        end
                        bq.delete();
                    end else if (lst) begin
                        err_exp = 1'b1;
                        bq.delete();
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd records produced", 112'(good_cnt > 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
